// File: rtl/eco_gate_pkg.sv
// Shared types and constants for the eco_gate_pipe slice.
// Mode encodings, result type, stage bundle and MISR step.
package eco_gate_pkg;

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_NAND = 2'b01;
  localparam logic [1:0] MODE_OR   = 2'b10;
  localparam logic [1:0] MODE_XNOR = 2'b11;

  localparam int          SIG_W    = 16;
  localparam logic [15:0] SIG_SEED = 16'h0000;

  typedef logic [2:0] res_t;

  typedef struct packed {
    logic vld;
    res_t res;
  } stage_t;

  function automatic logic [SIG_W-1:0] misr_next(
    input logic [SIG_W-1:0] s,
    input res_t             r
  );
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb} ^ {13'b0, r};
  endfunction

endpackage

// File: rtl/eco_gate_cone.sv
// Combinational gate cone: reduces a/b to a 3-bit result.
// Kept separate so an ECO can swap just this network.
module eco_gate_cone
  import eco_gate_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output res_t             y
);

  logic [WIDTH-1:0] mid;

  always_comb begin
    mid = '0;
    unique case (1'b1)
      (mode == MODE_AND):  mid = a & b;
      (mode == MODE_NAND): mid = ~(a & b);
      (mode == MODE_OR):   mid = a | b;
      (mode == MODE_XNOR): mid = ~(a ^ b);
      default:             mid = '0;
    endcase
  end

  assign y = {&(a | b), |mid, ^(a ^ b)};

endmodule

// File: rtl/eco_gate_pipe.sv
// Gate cone followed by a STAGES-deep valid/ready pipeline.
// Optional output MISR enabled by macro ECO_GATE_PIPE_SIG_EN.
module eco_gate_pipe
  import eco_gate_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       y,
  input  logic             sig_clr,
  output logic [15:0]      sig
);

  res_t        cone_y;
  stage_t      stg [STAGES];
  stage_t      src [STAGES];
  logic [STAGES-1:0] rdy;

  eco_gate_cone #(.WIDTH(WIDTH)) u_cone (
    .a    (a),
    .b    (b),
    .mode (mode),
    .y    (cone_y)
  );

  // A stage can load unless it and everything after it is full
  // and the consumer is stalling.
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full_tail = full_tail & stg[i].vld;
      rdy[i]    = !full_tail | out_ready;
    end
  end

  always_comb begin
    src[0] = '{vld: in_valid, res: cone_y};
    for (int i = 1; i < STAGES; i++) begin
      src[i] = stg[i-1];
    end
  end

  // Result bits only update with a valid beat so y holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          stg[i].vld <= src[i].vld;
          if (src[i].vld) begin
            stg[i].res <= src[i].res;
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = stg[STAGES-1].vld;
  assign y         = stg[STAGES-1].res;

`ifdef ECO_GATE_PIPE_SIG_EN
  logic [SIG_W-1:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SIG_SEED;
    end else if (sig_clr) begin
      sig_q <= '0;
    end else if (out_valid && out_ready) begin
      sig_q <= misr_next(sig_q, y);
    end
  end

  assign sig = sig_q;
`else
  logic unused_sig_clr;
  assign unused_sig_clr = sig_clr;
  assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_eco_gate_pipe.sv
// Directed and randomised checks for eco_gate_pipe.
// Instances: STAGES=2 (idx 0), STAGES=1 (idx 1), STAGES=4 (idx 2).
module tb_eco_gate_pipe;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] a     = '0;
  logic [4:0] b     = '0;
  logic [1:0] mode  = '0;
  logic [2:0] iv    = '0;
  logic [2:0] ordy  = '0;
  logic       clr   = 1'b0;
  wire  [2:0] ir;
  wire  [2:0] ov;
  wire  [2:0] y_w   [3];
  wire [15:0] sig_w [3];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  eco_gate_pipe #(.WIDTH(5), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .mode(mode),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .y(y_w[0]), .sig_clr(clr), .sig(sig_w[0])
  );

  eco_gate_pipe #(.WIDTH(5), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .mode(mode),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .y(y_w[1]), .sig_clr(clr), .sig(sig_w[1])
  );

  eco_gate_pipe #(.WIDTH(5), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .mode(mode),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .y(y_w[2]), .sig_clr(clr), .sig(sig_w[2])
  );

  function automatic logic [2:0] model(
    input logic [4:0] fa,
    input logic [4:0] fb,
    input logic [1:0] fm
  );
    logic [4:0] t;
    case (fm)
      2'b00:   t = fa & fb;
      2'b01:   t = ~(fa & fb);
      2'b10:   t = fa | fb;
      default: t = ~(fa ^ fb);
    endcase
    return {&(fa | fb), |t, ^(fa ^ fb)};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_run++;
    if (ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got=%b want=0", ov[0]);
    end
    n_run++;
    if (ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b want=1", ir[0]);
    end
    n_run++;
    if (y_w[0] !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_y got=%b want=000", y_w[0]);
    end
    n_run++;
    if (sig_w[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_sig got=%h want=0000", sig_w[0]);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    a = 5'h1F; b = 5'h00; mode = 2'b00;
    iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(negedge clk);
    n_run++;
    if (ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early got=%b want=0", ov[0]);
    end
    @(negedge clk);
    n_run++;
    if (ov[0] !== 1'b1 || y_w[0] !== 3'b101) begin
      n_fail++;
      $display("FAIL lat_and got=%b/%b want=1/101", ov[0], y_w[0]);
    end
    @(negedge clk);
    n_run++;
    if (ov[0] !== 1'b0 || y_w[0] !== 3'b101) begin
      n_fail++;
      $display("FAIL y_hold got=%b/%b want=0/101", ov[0], y_w[0]);
    end
  endtask

  task automatic test_modes();
    logic [1:0] mt [3];
    logic [2:0] et [3];
    mt[0] = 2'b01; et[0] = 3'b111;
    mt[1] = 2'b11; et[1] = 3'b101;
    mt[2] = 2'b10; et[2] = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 5'h1F; b = 5'h00; mode = mt[i];
      iv[0] = 1'b1; ordy[0] = 1'b1;
      @(posedge clk);
      #1 iv[0] = 1'b0;
      mode = 2'b00;
      repeat (2) @(negedge clk);
      n_run++;
      if (ov[0] !== 1'b1 || y_w[0] !== et[i]) begin
        n_fail++;
        $display("FAIL mode_%b got=%b/%b want=1/%b",
                 mt[i], ov[0], y_w[0], et[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [2:0] q [$];
    logic [2:0] e;
    int idx = 0;
    int got = 0;
    ordy[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a = 5'(idx * 3 + 1); b = 5'(idx * 7); mode = 2'(idx);
      iv[0] = 1'b1;
      #1;
      if (ir[0]) begin
        q.push_back(model(a, b, mode));
        idx++;
      end
    end
    n_run++;
    if (idx != 2 || ir[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_absorb got=%0d/%b want=2/0", idx, ir[0]);
    end
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      ordy[0] = 1'b1;
      if (idx < 8) begin
        a = 5'(idx * 3 + 1); b = 5'(idx * 7); mode = 2'(idx);
        iv[0] = 1'b1;
      end else begin
        iv[0] = 1'b0;
      end
      #1;
      if (c == 0) begin
        n_run++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_full_rate got=%b/%b want=1/1", ir[0], ov[0]);
        end
      end
      if (ov[0] && ordy[0]) begin
        e = (q.size() > 0) ? q.pop_front() : 3'bxxx;
        n_run++;
        if (y_w[0] !== e) begin
          n_fail++;
          $display("FAIL bp_beat%0d got=%b want=%b", got, y_w[0], e);
        end
        got++;
      end
      if (iv[0] && ir[0]) begin
        q.push_back(model(a, b, mode));
        idx++;
      end
    end
    iv[0] = 1'b0;
    n_run++;
    if (got != 8 || idx != 8) begin
      n_fail++;
      $display("FAIL bp_count got=%0d/%0d want=8/8", got, idx);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    @(negedge clk);
    ordy[0] = 1'b0;
    a = 5'h1F; b = 5'h00; mode = 2'b00;
    iv[0] = 1'b1;
    repeat (2) @(negedge clk);
    iv[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_run++;
    if (ov[0] !== 1'b0 || y_w[0] !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset got=%b/%b want=0/000", ov[0], y_w[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) stale++;
    end
    n_run++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL mid_stale got=%0d want=0", stale);
    end
  endtask

  task automatic send_one_wait();
    int c = 0;
    @(negedge clk);
    a = 5'h01; b = 5'h00; mode = 2'b00;
    iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    while (ov[0] !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    if (c >= 10) begin
      n_run++;
      n_fail++;
      $display("FAIL sig_wait got=timeout want=out_valid");
    end
  endtask

  task automatic test_sig();
    logic [15:0] e1;
    logic [15:0] e2;
`ifdef ECO_GATE_PIPE_SIG_EN
    e1 = 16'h0001;
`else
    e1 = 16'h0000;
`endif
    e2 = 16'h0000;
    send_one_wait();
    @(negedge clk);
    n_run++;
    if (sig_w[0] !== e1) begin
      n_fail++;
      $display("FAIL sig_update got=%h want=%h", sig_w[0], e1);
    end
    send_one_wait();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_run++;
    if (sig_w[0] !== e2) begin
      n_fail++;
      $display("FAIL sig_clear got=%h want=%h", sig_w[0], e2);
    end
  endtask

  task automatic test_random(input int k, input int n);
    logic [2:0] q [$];
    logic [2:0] e;
    int sent = 0;
    int got  = 0;
    logic hold = 1'b0;
    for (int c = 0; c < 3000 && got < n; c++) begin
      @(negedge clk);
      if (!hold) begin
        if (sent < n && $urandom_range(3) != 0) begin
          a = 5'($urandom); b = 5'($urandom); mode = 2'($urandom);
          iv[k] = 1'b1;
        end else begin
          iv[k] = 1'b0;
        end
      end
      ordy[k] = ($urandom_range(2) != 0);
      #1;
      if (ov[k] && ordy[k]) begin
        e = (q.size() > 0) ? q.pop_front() : 3'bxxx;
        n_run++;
        if (y_w[k] !== e) begin
          n_fail++;
          $display("FAIL rnd%0d_beat%0d got=%b want=%b", k, got, y_w[k], e);
        end
        got++;
      end
      if (iv[k] && ir[k]) begin
        q.push_back(model(a, b, mode));
        sent++;
        hold = 1'b0;
      end else begin
        hold = iv[k];
      end
    end
    @(negedge clk);
    iv[k] = 1'b0;
    ordy[k] = 1'b0;
    n_run++;
    if (got != n) begin
      n_fail++;
      $display("FAIL rnd%0d_count got=%0d want=%0d", k, got, n);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_backpressure();
    test_reset_mid();
    test_sig();
    test_random(1, 40);
    test_random(2, 40);
    test_random(0, 40);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
